// File: rtl/vending_pkg.sv
// Shared types and default sizing for the vending controller.
package vending_pkg;

    localparam int DEF_NUM_PROD = 3;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_STOCK_W  = 4;

    typedef enum logic [1:0] {
        LD_PRICE = 2'd0,
        LD_STOCK = 2'd1,
        SELL     = 2'd2
    } state_t;

endpackage

// File: rtl/vend_table.sv
// Per-product price/stock registers with a shared load index and a guarded stock decrement.
module vend_table
    import vending_pkg::*;
#(
    parameter int NUM_PROD = DEF_NUM_PROD,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int STOCK_W  = DEF_STOCK_W,
    localparam int SEL_W   = $clog2(NUM_PROD + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DATA_W-1:0]                   data,
    input  logic                                load_price,
    input  logic                                load_stock,
    input  logic                                dec,
    input  logic [SEL_W-1:0]                    dec_sel,
    output logic [NUM_PROD-1:0][DATA_W-1:0]     price,
    output logic [NUM_PROD-1:0][STOCK_W-1:0]    stock,
    output logic [NUM_PROD-1:0]                 empty,
    output logic                                last
);

    logic [SEL_W-1:0] idx;

    assign last = (idx == SEL_W'(NUM_PROD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            price <= '0;
            stock <= '0;
            empty <= '1;
        end else begin
            // One index serves both load phases; it wraps after the last product.
            if (load_price || load_stock)
                idx <= last ? '0 : idx + 1'b1;
            for (int k = 0; k < NUM_PROD; k++) begin
                if (load_price && idx == SEL_W'(k))
                    price[k] <= data;
                if (load_stock && idx == SEL_W'(k)) begin
                    stock[k] <= data[STOCK_W-1:0];
                    empty[k] <= (data[STOCK_W-1:0] == '0);
                end
                if (dec && dec_sel == SEL_W'(k + 1) && stock[k] != '0) begin
                    stock[k] <= stock[k] - 1'b1;
                    empty[k] <= (stock[k] == STOCK_W'(1));
                end
            end
        end
    end

endmodule

// File: rtl/vending_n.sv
// Multi-product vending controller: load prices and stock, then accumulate credit and sell.
//
//   state    | meaning
//   LD_PRICE | latching one price per cycle from DI
//   LD_STOCK | latching one stock count per cycle from DI
//   SELL     | accepting money, selections and refunds
module vending_n
    import vending_pkg::*;
#(
    parameter int NUM_PROD = DEF_NUM_PROD,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int STOCK_W  = DEF_STOCK_W,
    localparam int SEL_W   = $clog2(NUM_PROD + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   DI,
    input  logic [DATA_W-1:0]   MI,
    input  logic [SEL_W-1:0]    sel,
    input  logic                cancel,
    output logic [DATA_W-1:0]   MO,
    output logic [SEL_W-1:0]    PO,
    output logic                rdy,
    output logic [NUM_PROD-1:0] empty
);

    state_t                             state;
    logic [DATA_W-1:0]                  credit;
    logic [DATA_W:0]                    sum;
    logic [DATA_W:0]                    change;
    logic [NUM_PROD-1:0][DATA_W-1:0]    price;
    logic [NUM_PROD-1:0][STOCK_W-1:0]   stock;
    logic                               tbl_last;
    logic                               sel_valid;
    logic [DATA_W-1:0]                  sel_price;
    logic [STOCK_W-1:0]                 sel_stock;
    logic                               load_price;
    logic                               load_stock;
    logic                               dispense;

    assign sum    = {1'b0, credit} + {1'b0, MI};
    assign change = sum - {1'b0, sel_price};

    always_comb begin
        sel_valid = 1'b0;
        sel_price = '0;
        sel_stock = '0;
        for (int k = 0; k < NUM_PROD; k++) begin
            if (sel == SEL_W'(k + 1)) begin
                sel_valid = 1'b1;
                sel_price = price[k];
                sel_stock = stock[k];
            end
        end
    end

    assign load_price = (state == LD_PRICE);
    assign load_stock = (state == LD_STOCK);
    assign dispense   = (state == SELL) && !cancel && sel_valid &&
                        (sel_stock != '0) && (sum >= {1'b0, sel_price});

    vend_table #(
        .NUM_PROD (NUM_PROD),
        .DATA_W   (DATA_W),
        .STOCK_W  (STOCK_W)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .data       (DI),
        .load_price (load_price),
        .load_stock (load_stock),
        .dec        (dispense),
        .dec_sel    (sel),
        .price      (price),
        .stock      (stock),
        .empty      (empty),
        .last       (tbl_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= LD_PRICE;
            credit <= '0;
            MO     <= '0;
            PO     <= '0;
            rdy    <= 1'b0;
        end else begin
            MO <= '0;
            PO <= '0;
            case (state)
                LD_PRICE: if (tbl_last) state <= LD_STOCK;
                LD_STOCK: if (tbl_last) begin
                    state <= SELL;
                    rdy   <= 1'b1;
                end
                SELL: begin
                    if (cancel) begin
                        MO     <= sum[DATA_W-1:0];
                        credit <= '0;
                    end else if (sel_valid) begin
                        if (sel_stock == '0) begin
                            MO     <= sum[DATA_W-1:0];
                            credit <= '0;
                        end else if (dispense) begin
                            PO     <= sel;
                            MO     <= change[DATA_W-1:0];
                            credit <= '0;
                        end else begin
                            credit <= sum[DATA_W-1:0];
                        end
                    end else if (sum[DATA_W]) begin
                        // Coin would overflow the credit register: hand it straight back.
                        MO <= MI;
                    end else begin
                        credit <= sum[DATA_W-1:0];
                    end
                end
                default: state <= LD_PRICE;
            endcase
        end
    end

endmodule

// File: tb/tb_vending_n.sv
// Directed and randomized checks of vending_n against a transaction-level model.
module tb_vending_n;

    localparam int NUM_PROD = 3;
    localparam int DATA_W   = 8;
    localparam int STOCK_W  = 4;
    localparam int SEL_W    = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [DATA_W-1:0]   DI = '0;
    logic [DATA_W-1:0]   MI = '0;
    logic [SEL_W-1:0]    sel = '0;
    logic                cancel = 1'b0;
    logic [DATA_W-1:0]   MO;
    logic [SEL_W-1:0]    PO;
    logic                rdy;
    logic [NUM_PROD-1:0] empty;

    int n_cmp = 0;
    int n_bad = 0;
    int m_price [NUM_PROD];
    int m_stock [NUM_PROD];
    int m_credit;

    vending_n #(
        .NUM_PROD (NUM_PROD),
        .DATA_W   (DATA_W),
        .STOCK_W  (STOCK_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .DI     (DI),
        .MI     (MI),
        .sel    (sel),
        .cancel (cancel),
        .MO     (MO),
        .PO     (PO),
        .rdy    (rdy),
        .empty  (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_empty();
        logic [31:0] e = '0;
        for (int k = 0; k < NUM_PROD; k++)
            if (m_stock[k] == 0) e[k] = 1'b1;
        return e;
    endfunction

    task automatic do_reset();
        rst    = 1'b1;
        MI     = DATA_W'($urandom);
        sel    = SEL_W'($urandom);
        cancel = 1'b0;
        @(posedge clk); #1;
        rst    = 1'b0;
        MI     = '0;
        sel    = '0;
        for (int k = 0; k < NUM_PROD; k++) begin
            m_price[k] = 0;
            m_stock[k] = 0;
        end
        m_credit = 0;
        chk("rst_mo", MO, 0);
        chk("rst_po", PO, 0);
        chk("rst_rdy", rdy, 0);
        chk("rst_empty", empty, 3'b111);
    endtask

    // Inputs other than DI are randomized while loading; they must have no effect.
    task automatic load(input int p [NUM_PROD], input int s [NUM_PROD]);
        for (int i = 0; i < NUM_PROD; i++) begin
            DI     = DATA_W'(p[i]);
            MI     = DATA_W'($urandom);
            sel    = SEL_W'($urandom);
            cancel = 1'($urandom);
            @(posedge clk); #1;
            m_price[i] = p[i];
            chk("ldp_mo", MO, 0);
            chk("ldp_po", PO, 0);
            chk("ldp_rdy", rdy, 0);
        end
        for (int i = 0; i < NUM_PROD; i++) begin
            DI     = DATA_W'(s[i] + 16 * $urandom_range(0, 15));
            MI     = DATA_W'($urandom);
            sel    = SEL_W'($urandom);
            cancel = 1'($urandom);
            @(posedge clk); #1;
            m_stock[i] = s[i];
            chk("lds_mo", MO, 0);
            chk("lds_po", PO, 0);
            chk("lds_rdy", rdy, (i == NUM_PROD - 1) ? 1 : 0);
            chk("lds_empty", empty, exp_empty());
        end
        DI = '0; MI = '0; sel = '0; cancel = 1'b0;
    endtask

    task automatic step(input string tag, input int mi, input int s, input bit c);
        int sum;
        int emo = 0;
        int epo = 0;
        MI     = DATA_W'(mi);
        sel    = SEL_W'(s);
        cancel = c;
        sum    = m_credit + mi;
        if (c) begin
            emo = sum % 256;
            m_credit = 0;
        end else if (s >= 1 && s <= NUM_PROD) begin
            if (m_stock[s-1] == 0) begin
                emo = sum % 256;
                m_credit = 0;
            end else if (sum >= m_price[s-1]) begin
                epo = s;
                emo = (sum - m_price[s-1]) % 256;
                m_stock[s-1]--;
                m_credit = 0;
            end else begin
                m_credit = sum;
            end
        end else if (sum > 255) begin
            emo = mi;
        end else begin
            m_credit = sum;
        end
        @(posedge clk); #1;
        chk({tag, "_mo"}, MO, emo);
        chk({tag, "_po"}, PO, epo);
        chk({tag, "_empty"}, empty, exp_empty());
        chk({tag, "_rdy"}, rdy, 1);
        MI = '0; sel = '0; cancel = 1'b0;
    endtask

    initial begin
        int p [NUM_PROD];
        int s [NUM_PROD];

        do_reset();
        p = '{15, 20, 30};
        s = '{2, 1, 0};
        load(p, s);

        step("buy1", 20, 1, 0);
        step("idle1", 0, 0, 0);

        step("acc_a", 10, 2, 0);
        step("acc_b", 5, 2, 0);
        step("buy2", 5, 2, 0);
        chk("empty1_bit", empty[1], 1);

        step("soldout", 50, 3, 0);
        step("cr_zero", 0, 0, 1);

        step("acc_c", 10, 0, 0);
        step("cancel", 4, 1, 1);

        step("fill250", 250, 0, 0);
        step("reject", 10, 0, 0);
        step("buy250", 0, 1, 0);

        step("pre_rst", 12, 0, 0);
        do_reset();
        p = '{10, 0, 25};
        s = '{5, 3, 9};
        load(p, s);
        step("no_credit", 0, 0, 1);
        step("reload1", 10, 1, 0);
        step("price0", 7, 2, 0);

        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < NUM_PROD; i++) begin
                p[i] = $urandom_range(0, 60);
                s[i] = $urandom_range(0, 5);
            end
            load(p, s);
            for (int n = 0; n < 150; n++) begin
                int mi;
                mi = ($urandom_range(0, 9) == 0) ? $urandom_range(150, 255)
                                                 : $urandom_range(0, 30);
                step("rnd", mi, $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vending_n.md
VENDING_N -- requirements
Module: vending_n

Interface
REQ-001 SHALL have parameter NUM_PROD, default 3, meaning the number of products.
REQ-002 SHALL have parameter DATA_W, default 8, meaning the width of price, money and change.
REQ-003 SHALL have parameter STOCK_W, default 4, meaning the width of each per-product stock counter.
REQ-004 SHALL have localparam SEL_W = $clog2(NUM_PROD+1), meaning the width of product codes (0 = none).
REQ-005 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port DI  input  DATA_W  configuration data (prices, then stock counts).
REQ-008 SHALL have port MI  input  DATA_W  money inserted this cycle.
REQ-009 SHALL have port sel  input  SEL_W  product select, 1..NUM_PROD; 0 = no selection.
REQ-010 SHALL have port cancel  input  1  refund request.
REQ-011 SHALL have port MO  output  DATA_W  change or refund, valid for one cycle.
REQ-012 SHALL have port PO  output  SEL_W  dispensed product code; 0 = nothing dispensed.
REQ-013 SHALL have port rdy  output  1  high while in SELL.
REQ-014 SHALL have port empty  output  NUM_PROD  bit k-1 set when product k stock is 0.

Function
REQ-015 SHALL implement FSM states LD_PRICE, LD_STOCK and SELL; it SHALL enter LD_PRICE on reset.
REQ-016 In LD_PRICE, SHALL latch DI as the price of product 1..NUM_PROD on successive cycles, one per cycle, then go to LD_STOCK.
REQ-017 In LD_STOCK, SHALL latch DI[STOCK_W-1:0] as the stock of product 1..NUM_PROD on successive cycles, then go to SELL.
REQ-018 During loading, SHALL ignore MI, sel and cancel, and SHALL hold MO=0 and PO=0.
REQ-019 Outputs SHALL be registered: the MO/PO response to inputs sampled at edge n SHALL appear after edge n and hold for exactly one cycle; otherwise MO=0 and PO=0.
REQ-020 In SELL, SHALL form sum = credit + MI at DATA_W+1 bits.
REQ-021 cancel=1 SHALL take priority over sel: MO=sum, PO=0, credit cleared.
REQ-022 For valid sel=k with stock[k]>0 and sum >= price[k]: PO=k, MO=sum-price[k], credit cleared, stock[k] decremented.
REQ-023 For valid sel=k with stock[k]=0 (sold out): PO=0, MO=sum, credit cleared.
REQ-024 For valid sel=k with sum < price[k]: PO=0, MO=0, credit=sum.
REQ-025 For sel=0 or sel > NUM_PROD: no selection; credit=sum.
REQ-026 Overflow: if no dispense or refund occurs and sum > 2^DATA_W-1, MO=MI and credit SHALL be unchanged (coin rejected).
REQ-027 Price 0 SHALL be legal: a select of an in-stock product dispenses with MO=sum.
REQ-028 Stock SHALL never wrap below 0.
REQ-029 empty and rdy SHALL be registered state-derived outputs.

Reset
REQ-030 On rst=1 at a clock edge, SHALL set MO=0, PO=0, rdy=0, credit=0, all prices=0, all stock=0, empty=all ones, state=LD_PRICE.
REQ-031 Reset mid-load or mid-transaction SHALL discard accumulated credit without refund and restart loading from product 1.

Structure
REQ-032 A package vending_pkg SHALL hold the state enum and the default NUM_PROD/DATA_W/STOCK_W constants.
REQ-033 The price/stock register file with its load index and decrement port SHALL be a sub-module vend_table; the FSM and credit datapath SHALL stay in vending_n.

Verification (NUM_PROD=3, DATA_W=8, STOCK_W=4)
REQ-034 Load prices 15,20,30 and stock 2,1,0; then MI=20, sel=1 -> next cycle MO=5, PO=1, then MO=0, PO=0.
REQ-035 MI=10, sel=2, then MI=5, sel=2, then MI=5, sel=2 -> MO=0,PO=0; MO=0,PO=0; MO=0,PO=2; afterwards empty[1]=1.
REQ-036 MI=50, sel=3 (stock 0) -> MO=50, PO=0; credit 0 afterward.
REQ-037 MI=10, sel=0, then MI=4, sel=1, cancel=1 -> second response MO=14, PO=0; stock[1] unchanged.
REQ-038 Credit 250, then MI=10, sel=0 -> MO=10 (rejected), credit stays 250; then sel=1 with MI=0 -> MO=235, PO=1.
REQ-039 Assert rst with credit 12 mid-SELL -> MO=0, PO=0, rdy=0, empty=3'b111; reload proceeds from product 1.
